// File: rtl/fire_bias_relu_requant.sv
// Per-channel bias add, ReLU, round-half-up shift and saturate to a signed activation.
// Latency 2 cycles; the whole pipeline stalls together when out_valid && !out_ready (in_ready = adv).
module fire_bias_relu_requant #(
  parameter int CHANNELS = 64,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 8,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] bias_mem [0:CHANNELS-1],
  input  logic             ch_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_last,
  output logic             err_last
);

  localparam int SW = ACC_W + 2;
  localparam logic [SW-1:0] RND = ({{(SW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic [SW-1:0] SAT = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

  logic [CH_W-1:0]  ch_cnt_q, ch_cnt_d, ch_sel, ch_inc;
  logic             err_q, err_d;
  logic             s1_vld_q, s1_last_q;
  logic [ACC_W:0]   s1_sum_q, sum_d;
  logic [CH_W-1:0]  s1_ch_q;
  logic             out_valid_q, out_last_q;
  logic [OUT_W-1:0] out_data_q, data_d;
  logic [CH_W-1:0]  out_ch_q;
  logic [ACC_W-1:0] bias;
  logic [SW-1:0]    sum_ext, rnd, r;
  logic             adv, accept;

  assign adv      = !out_valid_q || out_ready;
  assign accept   = in_valid && adv;
  assign in_ready = adv;

  // A restart in the same cycle as a beat steers that beat to channel 0.
  assign ch_sel = ch_clr ? '0 : ch_cnt_q;
  assign ch_inc = (ch_sel == CH_W'(CHANNELS - 1)) ? '0 : ch_sel + 1'b1;
  assign bias   = bias_mem[ch_sel];
  assign sum_d  = {in_acc[ACC_W-1], in_acc} + {bias[ACC_W-1], bias};

  always_comb begin
    ch_cnt_d = ch_cnt_q;
    err_d    = err_q;
    if (ch_clr) begin
      ch_cnt_d = accept ? ch_inc : '0;
      err_d    = 1'b0;
    end else if (accept) begin
      ch_cnt_d = ch_inc;
      if (in_last && ch_cnt_q != CH_W'(CHANNELS - 1))
        err_d = 1'b1;
    end
  end

  // Sum is non-negative whenever r is used, so a logical shift suffices.
  always_comb begin
    sum_ext = {s1_sum_q[ACC_W], s1_sum_q};
    rnd     = sum_ext + RND;
    r       = rnd >> SHIFT;
    data_d  = '0;
    if (!s1_sum_q[ACC_W])
      data_d = (r > SAT) ? SAT[OUT_W-1:0] : r[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt_q    <= '0;
      err_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_sum_q    <= '0;
      s1_ch_q     <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      err_q    <= err_d;
      if (adv) begin
        s1_vld_q    <= in_valid;
        out_valid_q <= s1_vld_q;
        if (accept) begin
          s1_sum_q  <= sum_d;
          s1_ch_q   <= ch_sel;
          s1_last_q <= in_last;
        end
        if (s1_vld_q) begin
          out_data_q <= data_d;
          out_ch_q   <= s1_ch_q;
          out_last_q <= s1_last_q;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign err_last  = err_q;

endmodule

// File: tb/tb_fire_bias_relu_requant.sv
// Directed bench with a scoreboard queue for fire_bias_relu_requant (SHIFT=8, 64 channels).
module tb_fire_bias_relu_requant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bias_mem [0:63];
  logic        ch_clr, in_valid, in_ready, in_last;
  logic [31:0] in_acc;
  logic        out_valid, out_ready, out_last, err_last;
  logic [15:0] out_data;
  logic [5:0]  out_ch;

  typedef struct packed {
    logic [15:0] d;
    logic [5:0]  ch;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   mch    = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  fire_bias_relu_requant #(.CHANNELS(64), .ACC_W(32), .OUT_W(16), .SHIFT(8)) dut (
    .clk(clk), .rst_n(rst_n), .bias_mem(bias_mem), .ch_clr(ch_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .err_last(err_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] acc, input logic [31:0] b);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(b));
    if (s < 0) return 16'd0;
    s = (s + 128) >>> 8;
    if (s > 32767) return 16'd32767;
    return s[15:0];
  endfunction

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      exp_t e;
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed ch %0d data %0d expected none", out_ch, out_data);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("out_data", out_data, e.d);
        check("out_ch", out_ch, e.ch);
        check("out_last", out_last, e.last);
      end
    end
  end

  // Leaves in_valid high so consecutive calls form back-to-back beats.
  task automatic send_beat(input logic [31:0] acc, input logic last, input int exp_d);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1;
    in_acc   = acc;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    e.ch   = ch_clr ? 6'd0 : 6'(mch);
    e.d    = (exp_d < 0) ? model(acc, bias_mem[e.ch]) : 16'(exp_d);
    e.last = last;
    sbq.push_back(e);
    mch = ch_clr ? 1 : (mch + 1) % 64;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 30) begin
      n++;
      @(posedge clk);
    end
    #1;
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic clr_pulse();
    ch_clr = 1'b1;
    @(posedge clk);
    #1;
    ch_clr = 1'b0;
    mch = 0;
  endtask

  logic [15:0] hold_d;
  logic [5:0]  hold_c;

  initial begin
    for (int i = 0; i < 64; i++) bias_mem[i] = 32'(i * 7919 - 250000);
    bias_mem[0] = -32'sd321;
    bias_mem[1] = 32'd290;
    bias_mem[2] = 32'd290;
    for (int i = 3; i < 7; i++) bias_mem[i] = 32'd0;
    bias_mem[7] = 32'hFFFF_FFFF;
    rst_n = 1'b0; ch_clr = 1'b0; in_valid = 1'b0; in_acc = '0; in_last = 1'b0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_last", err_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic path with latency checks
    send_beat(32'd1000, 1'b0, 3);
    idle();
    @(negedge clk); check("lat0_s1_valid", out_valid, 0);
    @(negedge clk); check("lat0_s2_valid", out_valid, 1);
    @(posedge clk); #1;
    send_beat(-32'sd400, 1'b0, 0);
    idle();
    @(negedge clk); check("lat1_s1_valid", out_valid, 0);
    @(negedge clk); check("lat1_s2_valid", out_valid, 1);
    @(posedge clk); #1;

    // Rounding, saturation and sign boundaries on channels 2..7
    send_beat(32'h7FFF_FFFF, 1'b0, 32767);
    send_beat(32'd384, 1'b0, 2);
    send_beat(32'd383, 1'b0, 1);
    send_beat(32'd127, 1'b0, 0);
    send_beat(32'd128, 1'b0, 1);
    send_beat(32'h8000_0000, 1'b0, 0);
    idle();
    drain();

    // Back-to-back stream with a 3-cycle consumer stall
    fork
      begin
        for (int i = 0; i < 10; i++) send_beat(32'(i * 60000 - 200000), 1'b0, -1);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        hold_d = out_data;
        hold_c = out_ch;
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_hold_data", out_data, hold_d);
          check("stall_hold_ch", out_ch, hold_c);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Channel wrap over 130 beats with last on beats 63 and 127
    clr_pulse();
    for (int i = 0; i < 130; i++)
      send_beat(32'(int'($urandom_range(0, 2000000)) - 1000000), (i == 63 || i == 127), -1);
    idle();
    drain();
    check("wrap_no_err", err_last, 0);

    // Misplaced last sets a sticky error; restart clears it
    clr_pulse();
    for (int i = 0; i < 10; i++) send_beat(32'(i * 1000), 1'b0, -1);
    check("err_before", err_last, 0);
    send_beat(32'd5000, 1'b1, -1);
    check("err_set", err_last, 1);
    send_beat(32'd6000, 1'b0, -1);
    send_beat(32'd7000, 1'b0, -1);
    idle();
    check("err_sticky", err_last, 1);
    clr_pulse();
    check("err_cleared", err_last, 0);
    send_beat(32'd1000, 1'b0, 3);
    idle();
    drain();

    // Restart coincident with a beat: that beat is channel 0, next is channel 1
    ch_clr = 1'b1;
    send_beat(32'd1000, 1'b0, 3);
    ch_clr = 1'b0;
    send_beat(-32'sd400, 1'b0, 0);
    idle();
    drain();

    // Reset with two beats held in the pipeline
    out_ready = 1'b0;
    send_beat(32'd2000, 1'b0, -1);
    send_beat(32'd3000, 1'b0, -1);
    idle();
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_ch", out_ch, 0);
    sbq.delete();
    mch = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send_beat(32'd1000, 1'b0, 3);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
